// File: rtl/multiplex_display_top.sv
// Keypad-to-display back end: a 4x4 keypad code decoder, plus a 3-digit
// time-multiplexed seven-segment driver that shares one segment bus.

module keypad_decoder (
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] bcd_value,
  output logic       valid
);
  always_comb begin
    bcd_value = 4'h0;
    valid     = 1'b0;
    case ({row, col})
      4'b00_00: begin bcd_value = 4'd1; valid = 1'b1; end
      4'b00_01: begin bcd_value = 4'd2; valid = 1'b1; end
      4'b00_10: begin bcd_value = 4'd3; valid = 1'b1; end
      4'b00_11: bcd_value = 4'hA;
      4'b01_00: begin bcd_value = 4'd4; valid = 1'b1; end
      4'b01_01: begin bcd_value = 4'd5; valid = 1'b1; end
      4'b01_10: begin bcd_value = 4'd6; valid = 1'b1; end
      4'b01_11: bcd_value = 4'hB;
      4'b10_00: begin bcd_value = 4'd7; valid = 1'b1; end
      4'b10_01: begin bcd_value = 4'd8; valid = 1'b1; end
      4'b10_10: begin bcd_value = 4'd9; valid = 1'b1; end
      4'b10_11: bcd_value = 4'hC;
      // Bottom row: '*' and '#' take the two codes left over after A-D.
      4'b11_00: bcd_value = 4'hE;
      4'b11_01: begin bcd_value = 4'd0; valid = 1'b1; end
      4'b11_10: bcd_value = 4'hF;
      4'b11_11: bcd_value = 4'hD;
      default: begin bcd_value = 4'h0; valid = 1'b0; end
    endcase
  end
endmodule

module sevseg (
  input  logic [3:0] code,
  output logic [6:0] segments
);
  always_comb begin
    segments = 7'h00;
    case (code)
      4'h0: segments = 7'h3F;
      4'h1: segments = 7'h06;
      4'h2: segments = 7'h5B;
      4'h3: segments = 7'h4F;
      4'h4: segments = 7'h66;
      4'h5: segments = 7'h6D;
      4'h6: segments = 7'h7D;
      4'h7: segments = 7'h07;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h6F;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h7C;
      4'hC: segments = 7'h39;
      4'hD: segments = 7'h5E;
      4'hE: segments = 7'h79;
      4'hF: segments = 7'h71;
      default: segments = 7'h00;
    endcase
  end
endmodule

module multiplex_display #(
  parameter int REFRESH_CNT = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  output logic [6:0] segments,
  output logic [2:0] enable_displays
);
  localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CNT - 1);

  typedef enum logic [1:0] {
    SEL_D0 = 2'd0,
    SEL_D1 = 2'd1,
    SEL_D2 = 2'd2
  } sel_t;

  logic [CW-1:0] cnt_reg, cnt_next;
  sel_t          sel_reg, sel_next;
  logic [3:0]    digit_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      sel_reg <= SEL_D0;
    end else begin
      cnt_reg <= cnt_next;
      sel_reg <= sel_next;
    end
  end

  always_comb begin
    cnt_next        = cnt_reg + 1'b1;
    sel_next        = sel_reg;
    enable_displays = 3'b001;
    digit_sel       = digit0;

    if (cnt_reg == CNT_MAX) begin
      cnt_next = '0;
      case (sel_reg)
        SEL_D0:  sel_next = SEL_D1;
        SEL_D1:  sel_next = SEL_D2;
        default: sel_next = SEL_D0;
      endcase
    end

    // Encoding 3 is unreachable; it falls back to display 0 so the enable stays one-hot.
    case (sel_reg)
      SEL_D1: begin enable_displays = 3'b010; digit_sel = digit1; end
      SEL_D2: begin enable_displays = 3'b100; digit_sel = digit2; end
      default: begin enable_displays = 3'b001; digit_sel = digit0; end
    endcase
  end

  sevseg u_sevseg (
    .code     (digit_sel),
    .segments (segments)
  );
endmodule

module multiplex_display_top #(
  parameter int REFRESH_CNT = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] row,
  input  logic [1:0] col,
  output logic [3:0] bcd_value,
  output logic       valid,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  output logic [6:0] segments,
  output logic [2:0] enable_displays
);
  keypad_decoder u_keypad (
    .row       (row),
    .col       (col),
    .bcd_value (bcd_value),
    .valid     (valid)
  );

  multiplex_display #(.REFRESH_CNT(REFRESH_CNT)) u_mux (
    .clk             (clk),
    .rst             (rst),
    .digit0          (digit0),
    .digit1          (digit1),
    .digit2          (digit2),
    .segments        (segments),
    .enable_displays (enable_displays)
  );
endmodule

// File: tb/tb_multiplex_display_top.sv
// Directed bench for multiplex_display_top: keypad and sevseg sweeps, scan timing,
// live digit update, mid-scan reset and a random one-hot soak, all via a scoreboard.

module tb_multiplex_display_top;
  localparam int RC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] row, col;
  logic [3:0] bcd_value;
  logic       valid;
  logic [3:0] digit0, digit1, digit2;
  logic [6:0] segments;
  logic [2:0] enable_displays;

  always #5 clk = ~clk;

  multiplex_display_top #(.REFRESH_CNT(RC)) dut (
    .clk             (clk),
    .rst             (rst),
    .row             (row),
    .col             (col),
    .bcd_value       (bcd_value),
    .valid           (valid),
    .digit0          (digit0),
    .digit1          (digit1),
    .digit2          (digit2),
    .segments        (segments),
    .enable_displays (enable_displays)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // {bcd_value, valid} per row*4+col
  logic [4:0] kp_tab [16] = '{{4'h1,1'b1}, {4'h2,1'b1}, {4'h3,1'b1}, {4'hA,1'b0},
                              {4'h4,1'b1}, {4'h5,1'b1}, {4'h6,1'b1}, {4'hB,1'b0},
                              {4'h7,1'b1}, {4'h8,1'b1}, {4'h9,1'b1}, {4'hC,1'b0},
                              {4'hE,1'b0}, {4'h0,1'b1}, {4'hF,1'b0}, {4'hD,1'b0}};

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic sb_push(input string tag, input logic [9:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [9:0] obs);
    sb_item_t it;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Expected display after k edges since reset release: each display holds RC cycles.
  task automatic scan_check(input string tag, input int k);
    int idx;
    logic [3:0] d;
    idx = (k / RC) % 3;
    d = (idx == 0) ? digit0 : (idx == 1) ? digit1 : digit2;
    sb_push(tag, {3'(1 << idx), seg_tab[d]});
    sb_check({enable_displays, segments});
  endtask

  initial begin
    int k;
    rst = 1'b1; row = 2'd0; col = 2'd0;
    digit0 = 4'd1; digit1 = 4'd2; digit2 = 4'd3;

    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_push("reset_state", {3'b001, 7'h06});
    sb_check({enable_displays, segments});

    for (int i = 0; i < 16; i++) begin
      row = 2'(i / 4);
      col = 2'(i % 4);
      sb_push("keypad", {5'b0, kp_tab[i]});
      #1;
      sb_check({5'b0, bcd_value, valid});
      @(negedge clk);
    end

    // Sevseg sweep through display 0 while reset holds the scan there.
    for (int i = 0; i < 16; i++) begin
      digit0 = 4'(i);
      sb_push("sevseg", {3'b001, seg_tab[i]});
      #1;
      sb_check({enable_displays, segments});
      @(negedge clk);
    end
    digit0 = 4'd1;

    rst = 1'b0;
    k = 0;
    #1;
    scan_check("scan_release", k);
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      scan_check("scan", k);
    end

    // Live update while display 1 is enabled (k=30).
    digit0 = 4'd7; digit1 = 4'd8; digit2 = 4'd9;
    #1;
    sb_push("live_update", {3'b010, 7'h7F});
    sb_check({enable_displays, segments});
    for (k = 31; k <= 50; k++) begin
      @(negedge clk);
      scan_check("scan_live", k);
    end

    // k=50: display 2 at count 10; reset mid-scan.
    rst = 1'b1;
    @(negedge clk);
    sb_push("mid_reset", {3'b001, 7'h07});
    sb_check({enable_displays, segments});
    rst = 1'b0;
    for (k = 1; k <= RC; k++) begin
      @(negedge clk);
      scan_check("after_reset", k);
    end

    for (k = RC + 1; k <= RC + 1000; k++) begin
      @(negedge clk);
      digit0 = 4'($urandom_range(0, 15));
      digit1 = 4'($urandom_range(0, 15));
      digit2 = 4'($urandom_range(0, 15));
      #1;
      scan_check("random_onehot", k);
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
